// File: rtl/input_vc_controller.sv
// input_vc_controller: steers input flits into per-VC buffers, forwards them with round-robin wormhole arbitration.
// Define INPUT_VC_ERR_CHECK_EN to enable per-VC packet framing error detection on err.
module input_vc_controller #(
    parameter int FLIT_WIDTH = 16,
    parameter int NUM_VC = 2,
    parameter int BUF_DEPTH = 4,
    localparam int VC_BITS = $clog2(NUM_VC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  input_empty,
    input  logic [FLIT_WIDTH-1:0] input_data,
    output logic                  input_read,
    output logic [NUM_VC-1:0]     buffer_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_WIDTH-1:0] out_data,
    output logic [VC_BITS-1:0]    out_vc,
    output logic [NUM_VC-1:0]     err
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
    localparam logic [VC_BITS:0] NV = (VC_BITS + 1)'(NUM_VC);
    localparam logic IDLE = 1'b0;
    localparam logic ACTIVE = 1'b1;

    logic [FLIT_WIDTH-1:0] mem [NUM_VC][BUF_DEPTH];
    logic [PW-1:0] wr_ptr [NUM_VC];
    logic [PW-1:0] rd_ptr [NUM_VC];
    logic [CW-1:0] count [NUM_VC];
    logic state;
    logic [VC_BITS-1:0] grant, rr_ptr, pick, vin;
    logic [VC_BITS:0] idx;
    logic found, vc_ok, pop;
    logic [NUM_VC-1:0] wr_en, rd_en;

    assign vin = input_data[FLIT_WIDTH-3 -: VC_BITS];
    assign vc_ok = {1'b0, vin} < NV;
    // Full check uses the registered count only: no same-cycle bypass when draining.
    assign input_read = !reset && !input_empty && !(vc_ok && count[vin] == FULL);

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign buffer_empty[v] = count[v] == '0;
        assign wr_en[v] = input_read && vin == VC_BITS'(v);
        assign rd_en[v] = pop && grant == VC_BITS'(v);
    end

    assign out_valid = state == ACTIVE && !buffer_empty[grant];
    assign out_data = out_valid ? mem[grant][rd_ptr[grant]] : '0;
    assign out_vc = grant;
    assign pop = out_valid && out_ready;

    // Reverse scan so the nonempty VC closest to rr_ptr wins.
    always_comb begin
        found = 1'b0;
        pick = '0;
        idx = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (VC_BITS + 1)'(i);
            idx = idx >= NV ? idx - NV : idx;
            if (!buffer_empty[idx[VC_BITS-1:0]]) begin
                found = 1'b1;
                pick = idx[VC_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                grant <= pick;
                rr_ptr <= pick == VC_BITS'(NUM_VC - 1) ? '0 : pick + 1'b1;
                state <= ACTIVE;
            end
        end else if (pop && out_data[FLIT_WIDTH-2]) begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CW'(wr_en[i]) - CW'(rd_en[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (input_read && vc_ok) mem[vin][wr_ptr[vin]] <= input_data;
    end

`ifdef INPUT_VC_ERR_CHECK_EN
    logic [NUM_VC-1:0] open_pkt;
    logic in_head, in_tail;

    assign in_head = input_data[FLIT_WIDTH-1];
    assign in_tail = input_data[FLIT_WIDTH-2];

    // A head on an open packet or a non-head on a closed one is a framing error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            open_pkt <= '0;
            err <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (wr_en[i]) begin
                    if (in_head == open_pkt[i]) err[i] <= 1'b1;
                    open_pkt[i] <= in_tail ? 1'b0 : in_head ? 1'b1 : open_pkt[i];
                end
            end
        end
    end
`else
    assign err = '0;
`endif
endmodule

// File: tb/tb_input_vc_controller.sv
// tb_input_vc_controller: directed self-checking bench for input_vc_controller (default parameters).
module tb_input_vc_controller;
    logic clk = 1'b0;
    logic reset, input_empty, input_read, out_valid, out_ready;
    logic [15:0] input_data, out_data;
    logic [1:0] buffer_empty, err;
    logic [0:0] out_vc;
    int total = 0;
    int bad = 0;
    logic [15:0] q[$];
    logic [15:0] s3d [6] = '{16'hA000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005};
    logic [15:0] s4d [9] = '{16'h8001, 16'h0001, 16'h4001, 16'h0000, 16'hA002, 16'h6002, 16'h0000, 16'hC007, 16'h0000};
    logic [0:0] s4v [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef INPUT_VC_ERR_CHECK_EN
    localparam logic [1:0] ERR6 = 2'b01;
`else
    localparam logic [1:0] ERR6 = 2'b00;
`endif

    always #5 clk = ~clk;

    input_vc_controller dut (
        .clk(clk), .reset(reset), .input_empty(input_empty), .input_data(input_data),
        .input_read(input_read), .buffer_empty(buffer_empty), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_vc(out_vc), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed();
        input_empty = q.size() == 0;
        input_data = q.size() == 0 ? 16'h0 : q[0];
    endtask

    task automatic cyc();
        logic r;
        #1;
        r = input_read;
        @(posedge clk);
        #1;
        if (r) void'(q.pop_front());
        feed();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [0:0] c);
        chk({tag, "_valid"}, out_valid, v);
        chk({tag, "_data"}, out_data, d);
        if (v) chk({tag, "_vc"}, out_vc, c);
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        q = {16'hC005};
        feed();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read", input_read, 0);
        chk("rst_empty", buffer_empty, 2'b11);
        chk("rst_err", err, 0);
        chk_out("rst", 1'b0, 16'h0, 1'b0);
        chk("rst_vc", out_vc, 0);
        reset = 1'b0;
        #1;
        chk("rel_read", input_read, 1);

        out_ready = 1'b1;
        cyc();
        chk("s2_empty", buffer_empty, 2'b10);
        chk("s2_idle", out_valid, 0);
        cyc();
        chk_out("s2_fwd", 1'b1, 16'hC005, 1'b0);
        cyc();
        chk("s2_done", out_valid, 0);
        chk("s2_empty2", buffer_empty, 2'b11);

        out_ready = 1'b0;
        q = {16'hA000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005};
        feed();
        repeat (4) cyc();
        chk("s3_full_read", input_read, 0);
        chk("s3_empty", buffer_empty, 2'b01);
        chk_out("s3_hold", 1'b1, 16'hA000, 1'b1);
        cyc();
        chk("s3_stall", input_read, 0);
        chk_out("s3_hold2", 1'b1, 16'hA000, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_out("s3_stream", 1'b1, s3d[i], 1'b1);
            if (i == 1) chk("s3_resume", input_read, 1);
            cyc();
        end
        chk("s3_drained", out_valid, 0);
        chk("s3_empty2", buffer_empty, 2'b11);
        q = {16'hC008, 16'h6000};
        feed();
        cyc();
        chk("s3_lock", out_valid, 0);
        chk("s3_lock_empty", buffer_empty, 2'b10);
        cyc();
        chk_out("s3_tail", 1'b1, 16'h6000, 1'b1);
        cyc();
        chk("s3_idle", out_valid, 0);
        cyc();
        chk_out("s3_next", 1'b1, 16'hC008, 1'b0);
        cyc();
        chk("s3_end", buffer_empty, 2'b11);

        out_ready = 1'b0;
        q = {16'h8001, 16'hA002, 16'h0001, 16'h6002, 16'h4001, 16'hC007};
        feed();
        repeat (6) cyc();
        chk("s4_empty", buffer_empty, 2'b00);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk_out("s4_seq", s4d[i] != 16'h0, s4d[i], s4v[i]);
            cyc();
        end
        chk("s4_end", buffer_empty, 2'b11);

        out_ready = 1'b0;
        q = {16'h8003, 16'h0003};
        feed();
        repeat (2) cyc();
        chk_out("s5_head", 1'b1, 16'h8003, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk_out("s5_body", 1'b1, 16'h0003, 1'b0);
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk_out("s5_rst", 1'b0, 16'h0, 1'b0);
        chk("s5_rst_empty", buffer_empty, 2'b11);
        chk("s5_rst_read", input_read, 0);
        cyc();
        reset = 1'b0;
        q = {16'hE000};
        feed();
        out_ready = 1'b1;
        repeat (2) cyc();
        chk_out("s5_vc1", 1'b1, 16'hE000, 1'b1);
        cyc();
        chk("s5_idle", out_valid, 0);
        chk("s5_err", err, 0);

        q = {16'h4000};
        feed();
        cyc();
        chk("s6_err", err, ERR6);
        cyc();
        chk_out("s6_fwd", 1'b1, 16'h4000, 1'b0);
        cyc();
        chk("s6_err_held", err, ERR6);
        chk("s6_idle", out_valid, 0);
        reset = 1'b1;
        #1;
        chk("s6_err_rst", err, 0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
